pe_flit_sink: RTL and testbench
===============================

// Module: pe_flit_sink
// PURPOSE
//  Local-PE receive end of the 3D-mesh router: consumes 40-bit flits from the router's PE output port
//  (req/grant handshake) and reassembles header/payload/tail sequences into packet descriptors.
//  Checks the header destination against this node, checksums payloads and counts errors.
//  Completed descriptors are queued for the PE core.
// PARAMETERS
//  MY_X         4'd2  node X address; header D_x must match
//  MY_Y         4'd1  node Y address; header D_y must match
//  MY_Z         4'd3  node Z address; header D_z must match
//  MAX_PAYLOAD  8     maximum payload flits per packet
//  DESC_DEPTH   4     descriptor queue entries (power of 2, >=2)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous active-low reset
//  flit_in    in   40  flit from router PE output (do_pe)
//  req_in     in   1   router has a valid flit on flit_in
//  grnt_out   out  1   sink can accept; flit taken on an edge where req_in & grnt_out
//  desc_valid out  1   descriptor queue head valid
//  desc_ready in   1   PE pops head when desc_valid & desc_ready
//  desc_src   out  12  {S_x,S_y,S_z} of head packet
//  desc_id    out  14  header tag bits [13:0]
//  desc_len   out  4   payload flit count (0..MAX_PAYLOAD)
//  desc_csum  out  38  XOR of payload bits [37:0]
//  pkt_cnt    out  16  packets delivered to queue, wraps
//  err_cnt    out  8   total errors, saturates at 8'hFF
//  err_pulse  out  3   one-cycle flags {misroute, orphan, overflow/no_tail}
// BEHAVIOUR
//  Flit: [39:38] 11=header 10=payload 01=tail 00=invalid (dropped, counted as orphan).
//   Header [37:26]=S_x,S_y,S_z; [25:14]=D_x,D_y,D_z; [13:0]=tag.
//  Reset: all outputs 0 except grnt_out=1 after release; FSM=IDLE; queue empty; counters 0.
//  grnt_out registered: low in cycle after queue reaches DESC_DEPTH entries, high again the cycle after
//   a pop leaves it below full. Flits presented while grnt_out=0 are not taken; router must hold them.
//  FSM (advances only on accepted flit):
//   IDLE: header, dest match -> BODY (latch src/tag, len=0, csum=0). Header, dest mismatch -> DROP,
//         misroute. Payload/tail/invalid -> stay, orphan.
//   BODY: payload, len<MAX -> len+1, csum^=flit[37:0]. Payload, len==MAX -> DROP, overflow.
//         Tail -> push descriptor, pkt_cnt+1, IDLE. Header -> discard current, no_tail flag,
//         then process header as in IDLE (same cycle).
//   DROP: payload ignored; tail -> IDLE; header -> processed as in IDLE.
//  Latency: descriptor visible on desc_* one cycle after tail accepted (desc_valid=1 next cycle if queue was empty).
//  Queue: FIFO; simultaneous push and pop allowed at any fill level incl. full-1 and full.
//   Push never lost: grnt_out guarantees a free slot.
//  err_cnt += popcount(err_pulse) per cycle, saturating. pkt_cnt wraps FFFF->0000.
//  Reset asserted mid-packet: partial packet discarded, queue flushed, no error counted.
// TESTING
//  1 Header D=(2,1,3) S=(0,0,0) tag=14'h1A5, payloads 38'h1, 38'h6, tail
//    -> desc_len=2, desc_csum=38'h7, desc_src=0, pkt_cnt=1.
//  2 Header D=(6,1,3), 2 payloads, tail -> no descriptor, err_pulse=3'b100 once, err_cnt=1.
//  3 Payload then tail with no header -> two orphan pulses, err_cnt=2, FSM stays IDLE.
//  4 Header, 9 payloads, tail (MAX=8) -> overflow on 9th, no descriptor;
//    following good packet delivered normally.
//  5 desc_ready=0, send 5 good packets -> grnt_out low after 4th, 5th held;
//    one pop -> 5th accepted, order preserved.
//  6 Header, payload, header, tail -> no_tail pulse, one descriptor with len=0 for second header;
//    rst low mid-packet -> queue empty, counters 0.

Source files
------------

// File: rtl/pe_flit_sink_if.sv
// Handshake bundle between the router PE output port, the flit sink and the PE core.
// The flit side uses req/grant and the descriptor side uses valid/ready.
interface pe_flit_sink_if;
    logic [39:0] flit_in;
    logic        req_in;
    logic        grnt_out;
    logic        desc_valid;
    logic        desc_ready;
    logic [11:0] desc_src;
    logic [13:0] desc_id;
    logic [3:0]  desc_len;
    logic [37:0] desc_csum;

    modport master (
        output flit_in, req_in, desc_ready,
        input  grnt_out, desc_valid, desc_src, desc_id, desc_len, desc_csum
    );

    modport slave (
        input  flit_in, req_in, desc_ready,
        output grnt_out, desc_valid, desc_src, desc_id, desc_len, desc_csum
    );
endinterface

// File: rtl/pe_flit_sink.sv
// Local-PE receive end of the mesh router: reassembles header/payload/tail flits into
// packet descriptors, checks the destination, checksums the payload and counts errors.
module pe_flit_sink #(
    parameter logic [3:0] MY_X        = 4'd2,
    parameter logic [3:0] MY_Y        = 4'd1,
    parameter logic [3:0] MY_Z        = 4'd3,
    parameter int         MAX_PAYLOAD = 8,
    parameter int         DESC_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst,
    pe_flit_sink_if.slave bus,
    output logic [15:0]   pkt_cnt,
    output logic [7:0]    err_cnt,
    output logic [2:0]    err_pulse
);
    localparam int             PTR_W    = $clog2(DESC_DEPTH);
    localparam logic [3:0]     MAX_LEN  = 4'(MAX_PAYLOAD);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DESC_DEPTH);
    localparam logic [1:0]     T_HDR    = 2'b11;
    localparam logic [1:0]     T_PAY    = 2'b10;
    localparam logic [1:0]     T_TAIL   = 2'b01;

    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

    typedef struct packed {
        logic [11:0] src;
        logic [13:0] id;
        logic [3:0]  len;
        logic [37:0] csum;
    } desc_t;

    state_t      state_reg, state_next;
    logic [11:0] src_reg, src_next;
    logic [13:0] id_reg, id_next;
    logic [3:0]  len_reg, len_next;
    logic [37:0] csum_reg, csum_next;

    logic             grnt_reg;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic [15:0]      pkt_cnt_reg;
    logic [7:0]       err_cnt_reg, err_cnt_next;
    logic [2:0]       err_pulse_reg;
    logic [8:0]       err_sum;
    desc_t            mem [DESC_DEPTH];
    desc_t            head;

    logic       take, push, pop, queue_valid;
    logic       misroute, orphan, overflow;
    logic [1:0] ftype;
    logic       dest_match;

    assign ftype       = bus.flit_in[39:38];
    assign dest_match  = (bus.flit_in[25:14] == {MY_X, MY_Y, MY_Z});
    assign take        = bus.req_in & grnt_reg;
    assign queue_valid = (count_reg != '0);
    assign pop         = queue_valid & bus.desc_ready;

    // State register together with the in-progress packet fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            id_reg    <= '0;
            len_reg   <= '0;
            csum_reg  <= '0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            id_reg    <= id_next;
            len_reg   <= len_next;
            csum_reg  <= csum_next;
        end
    end

    // Next state; a header is handled identically in every state, after flagging a
    // missing tail if a packet was open.
    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        id_next    = id_reg;
        len_next   = len_reg;
        csum_next  = csum_reg;
        push       = 1'b0;
        misroute   = 1'b0;
        orphan     = 1'b0;
        overflow   = 1'b0;
        if (take) begin
            case (ftype)
                T_HDR: begin
                    if (state_reg == BODY) overflow = 1'b1;
                    if (dest_match) begin
                        state_next = BODY;
                        src_next   = bus.flit_in[37:26];
                        id_next    = bus.flit_in[13:0];
                        len_next   = '0;
                        csum_next  = '0;
                    end else begin
                        state_next = DROP;
                        misroute   = 1'b1;
                    end
                end
                T_PAY: begin
                    case (state_reg)
                        IDLE: orphan = 1'b1;
                        BODY: begin
                            if (len_reg < MAX_LEN) begin
                                len_next  = len_reg + 4'd1;
                                csum_next = csum_reg ^ bus.flit_in[37:0];
                            end else begin
                                state_next = DROP;
                                overflow   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                T_TAIL: begin
                    case (state_reg)
                        IDLE: orphan = 1'b1;
                        BODY: begin
                            push       = 1'b1;
                            state_next = IDLE;
                        end
                        default: state_next = IDLE;
                    endcase
                end
                default: orphan = 1'b1;
            endcase
        end
    end

    // Outputs: queue occupancy, error accumulation and head-of-queue view
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        err_sum      = {1'b0, err_cnt_reg} + 9'(misroute) + 9'(orphan) + 9'(overflow);
        err_cnt_next = err_sum[8] ? 8'hFF : err_sum[7:0];
        head         = mem[rd_ptr_reg];
        bus.grnt_out   = grnt_reg;
        bus.desc_valid = queue_valid;
        bus.desc_src   = queue_valid ? head.src  : '0;
        bus.desc_id    = queue_valid ? head.id   : '0;
        bus.desc_len   = queue_valid ? head.len  : '0;
        bus.desc_csum  = queue_valid ? head.csum : '0;
        pkt_cnt        = pkt_cnt_reg;
        err_cnt        = err_cnt_reg;
        err_pulse      = err_pulse_reg;
    end

    // Grant looks at next occupancy so a tail can never arrive with the queue full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grnt_reg      <= 1'b1;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            pkt_cnt_reg   <= '0;
            err_cnt_reg   <= '0;
            err_pulse_reg <= '0;
        end else begin
            grnt_reg      <= (count_next < FULL_CNT);
            wr_ptr_reg    <= wr_ptr_reg + PTR_W'(push);
            rd_ptr_reg    <= rd_ptr_reg + PTR_W'(pop);
            count_reg     <= count_next;
            pkt_cnt_reg   <= pkt_cnt_reg + 16'(push);
            err_cnt_reg   <= err_cnt_next;
            err_pulse_reg <= {misroute, orphan, overflow};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= '{src: src_reg, id: id_reg, len: len_reg, csum: csum_reg};
    end
endmodule

// File: tb/tb_pe_flit_sink.sv
// Directed bench for pe_flit_sink: a table of flits with expected results, plus
// hand-written sequences for back-pressure, counter saturation and reset mid-packet.
module tb_pe_flit_sink;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_flit_sink_if bus();
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;
    logic [2:0]  err_pulse;

    pe_flit_sink #(
        .MY_X(4'd2), .MY_Y(4'd1), .MY_Z(4'd3), .MAX_PAYLOAD(8), .DESC_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse)
    );

    typedef struct {
        logic [39:0] flit;
        logic [2:0]  pulse;
        logic        vld;
        logic [11:0] src;
        logic [13:0] id;
        logic [3:0]  len;
        logic [37:0] csum;
        logic [15:0] pkt;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;
    localparam logic [39:0] TAIL = {2'b01, 38'h0};

    function automatic logic [39:0] hdr(input logic [3:0] sx, input logic [3:0] sy, input logic [3:0] sz,
                                        input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] dz,
                                        input logic [13:0] tag);
        return {2'b11, sx, sy, sz, dx, dy, dz, tag};
    endfunction

    function automatic logic [39:0] pay(input logic [37:0] d);
        return {2'b10, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [39:0] f, input logic [2:0] p, input logic v,
                       input logic [11:0] s, input logic [13:0] i, input logic [3:0] l,
                       input logic [37:0] c, input logic [15:0] pk, input logic [7:0] e);
        vec_t t;
        t.flit = f; t.pulse = p; t.vld = v; t.src = s; t.id = i;
        t.len = l; t.csum = c; t.pkt = pk; t.err = e;
        vecs.push_back(t);
    endtask

    // Called at a falling edge; returns at the falling edge after the flit is taken.
    task automatic send(input logic [39:0] f);
        int waitc = 0;
        bus.flit_in = f;
        bus.req_in  = 1'b1;
        while (bus.grnt_out !== 1'b1 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: flit %h not granted within %0d cycles", f, waitc);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.req_in  = 1'b0;
        bus.flit_in = '0;
    endtask

    initial begin
        bus.flit_in    = '0;
        bus.req_in     = 1'b0;
        bus.desc_ready = 1'b1;

        // Test 1: good packet
        add(hdr(4'd0, 4'd0, 4'd0, 4'd2, 4'd1, 4'd3, 14'h1A5), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd0, 8'd0);
        add(pay(38'h1), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd0, 8'd0);
        add(pay(38'h6), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd0, 8'd0);
        add(TAIL, 3'b000, 1'b1, 12'h000, 14'h1A5, 4'd2, 38'h7, 16'd1, 8'd0);
        // Test 2: X mismatch -> misroute, rest dropped
        add(hdr(4'd0, 4'd0, 4'd0, 4'd6, 4'd1, 4'd3, 14'h0AA), 3'b100, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd1);
        add(pay(38'h3), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd1);
        add(pay(38'h4), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd1);
        add(TAIL, 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd1);
        // Test 3: orphans in IDLE
        add(pay(38'h5), 3'b010, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd2);
        add(TAIL, 3'b010, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd3);
        // Test 4: nine payloads -> overflow, then good packet
        add(hdr(4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd3, 14'h2222), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd3);
        for (int k = 1; k <= 8; k++)
            add(pay(38'(k)), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd3);
        add(pay(38'h9), 3'b001, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd4);
        add(TAIL, 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd4);
        add(hdr(4'd4, 4'd5, 4'd6, 4'd2, 4'd1, 4'd3, 14'h3FFF), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd4);
        add(pay(38'h2A_AAAA_AAAA), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd4);
        add(pay(38'h15_5555_5555), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd1, 8'd4);
        add(TAIL, 3'b000, 1'b1, 12'h456, 14'h3FFF, 4'd2, 38'h3F_FFFF_FFFF, 16'd2, 8'd4);
        // Exactly MAX_PAYLOAD payloads is legal: XOR of 1..8 is 8
        add(hdr(4'hA, 4'hB, 4'hC, 4'd2, 4'd1, 4'd3, 14'h0042), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd2, 8'd4);
        for (int k = 1; k <= 8; k++)
            add(pay(38'(k)), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd2, 8'd4);
        add(TAIL, 3'b000, 1'b1, 12'hABC, 14'h0042, 4'd8, 38'h8, 16'd3, 8'd4);
        // Test 6a: header inside a packet -> no_tail, second packet kept with len 0
        add(hdr(4'd7, 4'd7, 4'd7, 4'd2, 4'd1, 4'd3, 14'h0011), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd3, 8'd4);
        add(pay(38'h123), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd3, 8'd4);
        add(hdr(4'd8, 4'd9, 4'hA, 4'd2, 4'd1, 4'd3, 14'h0022), 3'b001, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd3, 8'd5);
        add(TAIL, 3'b000, 1'b1, 12'h89A, 14'h0022, 4'd0, 38'h0, 16'd4, 8'd5);
        // Invalid flit type, then Y and Z mismatches, header accepted from DROP
        add(40'h00_1234_5678, 3'b010, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd4, 8'd6);
        add(hdr(4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd3, 14'h0001), 3'b100, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd4, 8'd7);
        add(TAIL, 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd4, 8'd7);
        add(hdr(4'd0, 4'd0, 4'd0, 4'd2, 4'd1, 4'd2, 14'h0002), 3'b100, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd4, 8'd8);
        add(hdr(4'd1, 4'd1, 4'd1, 4'd2, 4'd1, 4'd3, 14'h0077), 3'b000, 1'b0, 12'h0, 14'h0, 4'd0, 38'h0, 16'd4, 8'd8);
        add(TAIL, 3'b000, 1'b1, 12'h111, 14'h0077, 4'd0, 38'h0, 16'd5, 8'd8);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_grnt", 64'(bus.grnt_out), 64'd1);
        check("rst_valid", 64'(bus.desc_valid), 64'd0);
        check("rst_pkt", 64'(pkt_cnt), 64'd0);
        check("rst_err", 64'(err_cnt), 64'd0);
        check("rst_pulse", 64'(err_pulse), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            send(vecs[i].flit);
            $display("vec %0d flit=%h pulse=%b valid=%b pkt=%0d err=%0d",
                     i, vecs[i].flit, err_pulse, bus.desc_valid, pkt_cnt, err_cnt);
            check($sformatf("v%0d_pulse", i), 64'(err_pulse), 64'(vecs[i].pulse));
            check($sformatf("v%0d_valid", i), 64'(bus.desc_valid), 64'(vecs[i].vld));
            check($sformatf("v%0d_pkt", i), 64'(pkt_cnt), 64'(vecs[i].pkt));
            check($sformatf("v%0d_err", i), 64'(err_cnt), 64'(vecs[i].err));
            if (vecs[i].vld) begin
                check($sformatf("v%0d_src", i), 64'(bus.desc_src), 64'(vecs[i].src));
                check($sformatf("v%0d_id", i), 64'(bus.desc_id), 64'(vecs[i].id));
                check($sformatf("v%0d_len", i), 64'(bus.desc_len), 64'(vecs[i].len));
                check($sformatf("v%0d_csum", i), 64'(bus.desc_csum), 64'(vecs[i].csum));
            end
        end

        // err_cnt saturates at FF (starts at 8 here)
        for (int k = 0; k < 260; k++) send(40'h00_0000_0000);
        $display("saturation: err=%0d pulse=%b", err_cnt, err_pulse);
        check("sat_err", 64'(err_cnt), 64'hFF);
        check("sat_pulse", 64'(err_pulse), 64'b010);

        // Test 5: back-pressure with queue full, order preserved
        bus.desc_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(hdr(4'd1, 4'd1, 4'd1, 4'd2, 4'd1, 4'd3, 14'(256 + k)));
            send(TAIL);
            $display("bp pkt %0d queued: pkt=%0d grnt=%b", k, pkt_cnt, bus.grnt_out);
        end
        check("full_grnt", 64'(bus.grnt_out), 64'd0);
        check("full_pkt", 64'(pkt_cnt), 64'd9);
        check("full_head", 64'(bus.desc_id), 64'h100);
        fork
            send(hdr(4'd1, 4'd1, 4'd1, 4'd2, 4'd1, 4'd3, 14'h104));
            begin
                repeat (3) @(negedge clk);
                check("held_grnt", 64'(bus.grnt_out), 64'd0);
                bus.desc_ready = 1'b1;
                @(negedge clk);
                bus.desc_ready = 1'b0;
                check("pop_grnt", 64'(bus.grnt_out), 64'd1);
            end
        join
        send(TAIL);
        $display("bp pkt 4 queued: pkt=%0d grnt=%b", pkt_cnt, bus.grnt_out);
        check("refill_pkt", 64'(pkt_cnt), 64'd10);
        check("refill_grnt", 64'(bus.grnt_out), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d_valid", k), 64'(bus.desc_valid), 64'd1);
            check($sformatf("drain%0d_id", k), 64'(bus.desc_id), 64'(256 + k));
            $display("drain %0d id=%h", k, bus.desc_id);
            bus.desc_ready = 1'b1;
            @(negedge clk);
            bus.desc_ready = 1'b0;
        end
        check("drained_valid", 64'(bus.desc_valid), 64'd0);
        check("drained_grnt", 64'(bus.grnt_out), 64'd1);

        // Test 6b: reset mid-packet with a descriptor queued
        send(hdr(4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd3, 14'h0055));
        send(TAIL);
        send(hdr(4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd3, 14'h0056));
        send(pay(38'h77));
        rst = 1'b0;
        #1;
        $display("reset mid-packet: valid=%b pkt=%0d err=%0d", bus.desc_valid, pkt_cnt, err_cnt);
        check("mid_rst_valid", 64'(bus.desc_valid), 64'd0);
        check("mid_rst_pkt", 64'(pkt_cnt), 64'd0);
        check("mid_rst_err", 64'(err_cnt), 64'd0);
        check("mid_rst_pulse", 64'(err_pulse), 64'd0);
        check("mid_rst_grnt", 64'(bus.grnt_out), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.desc_ready = 1'b1;
        send(pay(38'h9));
        check("post_rst_orphan", 64'(err_pulse), 64'b010);
        check("post_rst_err", 64'(err_cnt), 64'd1);
        send(hdr(4'd5, 4'd6, 4'd7, 4'd2, 4'd1, 4'd3, 14'h0066));
        send(pay(38'h5));
        send(TAIL);
        $display("post-reset pkt: id=%h len=%0d csum=%h pkt=%0d", bus.desc_id, bus.desc_len, bus.desc_csum, pkt_cnt);
        check("post_rst_valid", 64'(bus.desc_valid), 64'd1);
        check("post_rst_src", 64'(bus.desc_src), 64'h567);
        check("post_rst_id", 64'(bus.desc_id), 64'h66);
        check("post_rst_len", 64'(bus.desc_len), 64'd1);
        check("post_rst_csum", 64'(bus.desc_csum), 64'h5);
        check("post_rst_pkt", 64'(pkt_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
